// File: rtl/netlist_vector_sequencer.sv
// netlist_vector_sequencer
// Streams test vectors into a combinational gate-level netlist. Each vector is held on dut_in
// for SETTLE cycles, then the netlist output is captured and compared with the expected bit.
// Mismatches are counted (saturating), and the index of the latest failing vector is kept.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   start           pulse to begin a run; ignored while busy
//   vec_valid/ready handshake with the vector source (ready is registered)
//   vec_data        stimulus vector; vec_exp expected output; vec_last marks the final vector
//   dut_in          registered drive to netlist inputs; dut_out netlist output
//   busy, done      run in progress; one-cycle pulse at end of run
//   vec_idx         vectors checked in the current run (wraps)
//   mismatch_cnt    failing vectors in the current run (saturates)
//   last_fail_idx   index of the most recent failing vector
module netlist_vector_sequencer #(
  parameter int unsigned IN_W   = 17,
  parameter int unsigned SETTLE = 2,   // legal range 1..15
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_data,
  input  logic             vec_exp,
  input  logic             vec_last,
  output logic [IN_W-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_idx,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] last_fail_idx
);

  localparam logic [3:0]       SettleInit = 4'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitVec,
    StApply,
    StCapture,
    StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic             exp_q, exp_d;
  logic             last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] mismatch_q, mismatch_d;
  logic [CNT_W-1:0] last_fail_q, last_fail_d;
  logic             vec_ready_q, vec_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    dut_in_d    = dut_in_q;
    exp_d       = exp_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    vec_idx_d   = vec_idx_q;
    mismatch_d  = mismatch_q;
    last_fail_d = last_fail_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StWaitVec;
          vec_idx_d   = '0;
          mismatch_d  = '0;
          last_fail_d = '0;
        end
      end
      StWaitVec: begin
        if (vec_valid && vec_ready_q) begin
          dut_in_d = vec_data;
          exp_d    = vec_exp;
          last_d   = vec_last;
          cnt_d    = SettleInit;
          state_d  = StApply;
        end
      end
      StApply: begin
        // Counter starts at SETTLE-1 so APPLY lasts exactly SETTLE cycles.
        if (cnt_q == 4'd0) begin
          state_d = StCapture;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCapture: begin
        if (dut_out != exp_q) begin
          if (mismatch_q != '1) begin
            mismatch_d = mismatch_q + CntOne;
          end
          last_fail_d = vec_idx_q;
        end
        vec_idx_d = vec_idx_q + CntOne;
        state_d   = last_q ? StFinish : StWaitVec;
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Status outputs are registered copies of the upcoming state.
    vec_ready_d = (state_d == StWaitVec);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StFinish);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      dut_in_q    <= '0;
      exp_q       <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= 4'd0;
      vec_idx_q   <= '0;
      mismatch_q  <= '0;
      last_fail_q <= '0;
      vec_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dut_in_q    <= dut_in_d;
      exp_q       <= exp_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      vec_idx_q   <= vec_idx_d;
      mismatch_q  <= mismatch_d;
      last_fail_q <= last_fail_d;
      vec_ready_q <= vec_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign vec_ready     = vec_ready_q;
  assign dut_in        = dut_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign vec_idx       = vec_idx_q;
  assign mismatch_cnt  = mismatch_q;
  assign last_fail_idx = last_fail_q;

endmodule

// File: tb/tb_netlist_vector_sequencer.sv
// Directed bench for netlist_vector_sequencer. Two instances share all stimulus: dut_a uses
// CNT_W=16, dut_b uses CNT_W=4 to exercise counter saturation and index wrap. A small
// behavioural netlist closes the loop from dut_in to dut_out.
module tb_netlist_vector_sequencer;

  localparam int unsigned IN_W = 17;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            vec_valid;
  logic [IN_W-1:0] vec_data;
  logic            vec_exp;
  logic            vec_last;

  logic            vec_ready_a, busy_a, done_a, dut_out_a;
  logic [IN_W-1:0] dut_in_a;
  logic [15:0]     vec_idx_a, mismatch_a, last_fail_a;

  logic            vec_ready_b, busy_b, done_b, dut_out_b;
  logic [IN_W-1:0] dut_in_b;
  logic [3:0]      vec_idx_b, mismatch_b, last_fail_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int illegal_chg = 0;
  logic xfer_edge = 1'b0;
  logic rst_edge  = 1'b0;
  logic [IN_W-1:0] prev_dut_in = '0;

  always #5 clk = ~clk;

  // Reference netlist: arbitrary mix of parity and gates.
  function automatic logic netlist(input logic [IN_W-1:0] x);
    return (^x) ^ (x[3] & x[9]) ^ (x[0] | x[16]);
  endfunction

  assign dut_out_a = netlist(dut_in_a);
  assign dut_out_b = netlist(dut_in_b);

  netlist_vector_sequencer #(.IN_W(IN_W), .SETTLE(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready_a),
    .vec_data(vec_data), .vec_exp(vec_exp), .vec_last(vec_last), .dut_in(dut_in_a),
    .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .vec_idx(vec_idx_a),
    .mismatch_cnt(mismatch_a), .last_fail_idx(last_fail_a)
  );

  netlist_vector_sequencer #(.IN_W(IN_W), .SETTLE(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready_b),
    .vec_data(vec_data), .vec_exp(vec_exp), .vec_last(vec_last), .dut_in(dut_in_b),
    .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .vec_idx(vec_idx_b),
    .mismatch_cnt(mismatch_b), .last_fail_idx(last_fail_b)
  );

  // dut_in may only change on a transfer edge or a reset edge.
  always @(posedge clk) begin
    xfer_edge <= vec_valid & vec_ready_a;
    rst_edge  <= rst;
  end

  always @(negedge clk) begin
    if (done_a) done_cnt++;
    if (dut_in_a !== prev_dut_in && !xfer_edge && !rst_edge) illegal_chg++;
    prev_dut_in = dut_in_a;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] vec_of(input int i, input int seed);
    return IN_W'(i * 32'h1A5B3 + seed * 32'h0F0F1 + 32'h00321);
  endfunction

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    done_cnt = 0;
    check("start_busy", 32'(busy_a), 1);
    check("start_ready", 32'(vec_ready_a), 1);
    check("start_idx_clr", 32'(vec_idx_a), 0);
    check("start_mis_clr", 32'(mismatch_a), 0);
    check("start_lf_clr", 32'(last_fail_a), 0);
  endtask

  // Send n vectors; bit i of flip inverts the expected value of vector i.
  task automatic run_vectors(input int n, input int seed, input logic [31:0] flip,
                             input bit gapped, input bit poke_start);
    int last_xfer;
    last_xfer = -1;
    for (int i = 0; i < n; i++) begin
      bit sent;
      int guard;
      sent  = 1'b0;
      guard = 0;
      vec_data = vec_of(i, seed);
      vec_exp  = netlist(vec_of(i, seed)) ^ flip[i];
      vec_last = (i == n - 1);
      while (!sent) begin
        logic xfer;
        vec_valid = gapped ? (cyc % 3 == 0) : 1'b1;
        start = poke_start && (i == 1);
        xfer = vec_valid & vec_ready_a;
        step();
        guard++;
        if (xfer) begin
          sent = 1'b1;
          check("dut_in_load", 32'(dut_in_a), 32'(vec_of(i, seed)));
          if (!gapped && last_xfer >= 0) check("throughput", 32'(cyc - last_xfer), 4);
          last_xfer = cyc;
        end else if (guard > 40) begin
          check("xfer_timeout", 0, 1);
          sent = 1'b1;
        end
      end
    end
    start = 1'b0;
    vec_valid = 1'b0;
    vec_last = 1'b0;
    begin
      int k;
      for (k = 0; k < 20 && !done_a; k++) step();
      check("done_seen", 32'(done_a), 1);
    end
    step();
    step();
    check("done_once", 32'(done_cnt), 1);
    check("idle_after", 32'(busy_a), 0);
    check("dut_in_stable", 32'(illegal_chg), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    vec_valid = 1'b0;
    vec_data = '0;
    vec_exp = 1'b0;
    vec_last = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy_a), 0);
    check("rst_ready", 32'(vec_ready_a), 0);
    check("rst_done", 32'(done_a), 0);
    check("rst_dut_in", 32'(dut_in_a), 0);
    check("rst_idx", 32'(vec_idx_a), 0);
    check("rst_mis", 32'(mismatch_a), 0);
    check("rst_lf", 32'(last_fail_a), 0);
    rst = 1'b0;
    step();
    check("idle_no_ready", 32'(vec_ready_a), 0);

    // 4 matching vectors, valid tied high, start poked while busy.
    start_run();
    run_vectors(4, 1, 32'h0, 1'b0, 1'b1);
    check("r4_idx", 32'(vec_idx_a), 4);
    check("r4_mis", 32'(mismatch_a), 0);
    check("r4_lf", 32'(last_fail_a), 0);

    // 5 vectors, expected inverted on indices 1 and 3.
    start_run();
    run_vectors(5, 2, 32'h0A, 1'b0, 1'b0);
    check("r5_idx", 32'(vec_idx_a), 5);
    check("r5_mis", 32'(mismatch_a), 2);
    check("r5_lf", 32'(last_fail_a), 3);

    // Same set with gapped valid: identical results.
    start_run();
    run_vectors(5, 2, 32'h0A, 1'b1, 1'b0);
    check("gap_idx", 32'(vec_idx_a), 5);
    check("gap_mis", 32'(mismatch_a), 2);
    check("gap_lf", 32'(last_fail_a), 3);

    // Reset during APPLY.
    start_run();
    vec_data = vec_of(0, 3);
    vec_exp = 1'b0;
    vec_valid = 1'b1;
    step();
    vec_valid = 1'b0;
    check("mid_loaded", 32'(dut_in_a), 32'(vec_of(0, 3)));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy_a), 0);
    check("mid_rst_dut_in", 32'(dut_in_a), 0);
    check("mid_rst_ready", 32'(vec_ready_a), 0);
    check("mid_rst_done", 32'(done_a), 0);
    for (int k = 0; k < 6; k++) step();
    check("mid_rst_no_done", 32'(done_cnt), 0);
    check("mid_rst_idle", 32'(busy_a), 0);

    // 17 failing vectors: CNT_W=4 instance saturates and wraps.
    start_run();
    run_vectors(17, 4, 32'h1FFFF, 1'b0, 1'b0);
    check("w16_idx", 32'(vec_idx_a), 17);
    check("w16_mis", 32'(mismatch_a), 17);
    check("w16_lf", 32'(last_fail_a), 16);
    check("w4_idx", 32'(vec_idx_b), 1);
    check("w4_mis", 32'(mismatch_b), 15);
    check("w4_lf", 32'(last_fail_b), 0);
    check("w4_busy", 32'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
